// File: rtl/calcu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calcu_pkg
// Description : Shared operation codes and flag bit positions for the
//               calculator execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package calcu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_MOD = 4'd3,
        OP_DIV = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_ROL = 4'd8,
        OP_ROR = 4'd9
    } op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage : calcu_pkg
`default_nettype wire

// File: rtl/calcu_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : calcu_alu_core
// Description : Combinational operation mux and status flag generation.
// Revision    : 1.0 - initial release
// ============================================================================
module calcu_alu_core
    import calcu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [3:0]   i_sel,
    output logic [N-1:0] o_res,
    output logic [3:0]   o_flags
);

    // N < 2**N for every legal N, so the width always fits in N bits
    localparam logic [N-1:0] c_width = N'(N);

    logic [N:0]     w_sum;
    logic [N:0]     w_diff;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_amt;
    logic [N-1:0]   w_rol;
    logic [N-1:0]   w_ror;
    logic [N-1:0]   w_res;
    logic           w_c;
    logic           w_v;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_prod = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};

    // A zero amount shifts the wrap-around term out by exactly N bits
    assign w_amt = i_b % c_width;
    assign w_rol = (i_a << w_amt) | (i_a >> (c_width - w_amt));
    assign w_ror = (i_a >> w_amt) | (i_a << (c_width - w_amt));

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (i_sel)
            OP_ADD: begin
                w_res = w_sum[N-1:0];
                w_c   = w_sum[N];
                w_v   = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
            end
            OP_SUB: begin
                w_res = w_diff[N-1:0];
                w_c   = w_diff[N];
                w_v   = (i_a[N-1] != i_b[N-1]) && (w_diff[N-1] != i_a[N-1]);
            end
            OP_MUL: begin
                w_res = w_prod[N-1:0];
                w_c   = |w_prod[2*N-1:N];
                w_v   = |w_prod[2*N-1:N];
            end
            OP_MOD: begin
                if (i_b == '0) begin
                    w_res = i_a;
                    w_v   = 1'b1;
                end else begin
                    w_res = i_a % i_b;
                end
            end
            OP_DIV: begin
                if (i_b == '0) begin
                    w_res = '1;
                    w_v   = 1'b1;
                end else begin
                    w_res = i_a / i_b;
                end
            end
            OP_AND: w_res = i_a & i_b;
            OP_OR:  w_res = i_a | i_b;
            OP_XOR: w_res = i_a ^ i_b;
            OP_ROL: begin
                w_res = w_rol;
                w_c   = (w_amt != '0) && w_rol[0];
            end
            OP_ROR: begin
                w_res = w_ror;
                w_c   = (w_amt != '0) && w_ror[N-1];
            end
            default: w_v = 1'b1;
        endcase
    end

    assign o_res           = w_res;
    assign o_flags[FLAG_N] = w_res[N-1];
    assign o_flags[FLAG_Z] = (w_res == '0);
    assign o_flags[FLAG_C] = w_c;
    assign o_flags[FLAG_V] = w_v;

endmodule : calcu_alu_core
`default_nettype wire

// File: rtl/calcu_alu.sv
`default_nettype none
// ============================================================================
// Module      : calcu_alu
// Description : Calculator execute stage; combinational ALU core followed by
//               a result/flag register with asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module calcu_alu
    import calcu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   seleccion,
    output logic [N-1:0] salida,
    output logic [3:0]   flags
);

    logic [N-1:0] w_res;
    logic [3:0]   w_flags;
    logic [N-1:0] r_salida;
    logic [3:0]   r_flags;

    calcu_alu_core #(
        .N (N)
    ) u_core (
        .i_a     (a),
        .i_b     (b),
        .i_sel   (seleccion),
        .o_res   (w_res),
        .o_flags (w_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_salida <= '0;
            r_flags  <= '0;
        end else begin
            r_salida <= w_res;
            r_flags  <= w_flags;
        end
    end

    assign salida = r_salida;
    assign flags  = r_flags;

endmodule : calcu_alu
`default_nettype wire

// File: tb/tb_calcu_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_calcu_alu
// Description : Scoreboard bench for calcu_alu at N=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calcu_alu;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] s;
        logic [3:0]   f;
        string        tag;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   seleccion;
    logic [W-1:0] salida;
    logic [3:0]   flags;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    calcu_alu #(
        .N (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .seleccion (seleccion),
        .salida    (salida),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check({e.tag, ".res"},   8'(salida), 8'(e.s));
            check({e.tag, ".flags"}, 8'(flags),  8'(e.f));
        end
    endtask

    // Drive one op at the falling edge and compare the op issued one cycle earlier
    task automatic step(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [3:0] ts,
                        input logic [W-1:0] es, input logic [3:0] ef, input string tag);
        exp_t e;
        @(negedge clk);
        pop_check();
        a         = ta;
        b         = tb_v;
        seleccion = ts;
        e.s   = es;
        e.f   = ef;
        e.tag = tag;
        q.push_back(e);
    endtask

    // Integer reference model; returns {result, flags}
    function automatic logic [W+3:0] model(input int ai, input int bi, input int op);
        int mask, r, c, v, sa, sb, ss, k;
        logic [W-1:0] av, rv;
        mask = (1 << W) - 1;
        sa = (ai >= (1 << (W-1))) ? ai - (1 << W) : ai;
        sb = (bi >= (1 << (W-1))) ? bi - (1 << W) : bi;
        r = 0; c = 0; v = 0;
        av = W'(ai);
        rv = '0;
        k  = bi % W;
        case (op)
            0: begin r = ai + bi; c = int'(r > mask); ss = sa + sb;
                     v = int'(ss > (1 << (W-1)) - 1 || ss < -(1 << (W-1))); end
            1: begin r = ai - bi; c = int'(ai < bi); ss = sa - sb;
                     v = int'(ss > (1 << (W-1)) - 1 || ss < -(1 << (W-1))); end
            2: begin r = ai * bi; c = int'(r > mask); v = c; end
            3: if (bi == 0) begin r = ai; v = 1; end else r = ai % bi;
            4: if (bi == 0) begin r = mask; v = 1; end else r = ai / bi;
            5: r = ai & bi;
            6: r = ai | bi;
            7: r = ai ^ bi;
            8: begin
                for (int i = 0; i < W; i++) rv[(i + k) % W] = av[i];
                r = int'(rv);
                c = (k != 0) ? int'(rv[0]) : 0;
            end
            9: begin
                for (int i = 0; i < W; i++) rv[i] = av[(i + k) % W];
                r = int'(rv);
                c = (k != 0) ? int'(rv[W-1]) : 0;
            end
            default: begin r = 0; v = 1; end
        endcase
        r = r & mask;
        return {W'(r), r[W-1] == 1'b1, r == 0, c != 0, v != 0};
    endfunction

    initial begin
        logic [W+3:0] m;
        logic [W-1:0] ra, rb;
        logic [3:0]   rs;

        rst_n = 1'b0;
        a = 4'd5; b = 4'd3; seleccion = 4'd0;
        #2;
        check("reset.res",   8'(salida), 8'h00);
        check("reset.flags", 8'(flags),  8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // a=1, b=1 across all ten ops
        step(4'd1, 4'd1, 4'd0, 4'd2, 4'b0000, "add_1_1");
        step(4'd1, 4'd1, 4'd1, 4'd0, 4'b0100, "sub_1_1");
        step(4'd1, 4'd1, 4'd2, 4'd1, 4'b0000, "mul_1_1");
        step(4'd1, 4'd1, 4'd3, 4'd0, 4'b0100, "mod_1_1");
        step(4'd1, 4'd1, 4'd4, 4'd1, 4'b0000, "div_1_1");
        step(4'd1, 4'd1, 4'd5, 4'd1, 4'b0000, "and_1_1");
        step(4'd1, 4'd1, 4'd6, 4'd1, 4'b0000, "or_1_1");
        step(4'd1, 4'd1, 4'd7, 4'd0, 4'b0100, "xor_1_1");
        step(4'd1, 4'd1, 4'd8, 4'd2, 4'b0000, "rol_1_1");
        step(4'd1, 4'd1, 4'd9, 4'd8, 4'b1010, "ror_1_1");

        // a=4, b=1
        step(4'd4, 4'd1, 4'd0, 4'd5, 4'b0000, "add_4_1");
        step(4'd4, 4'd1, 4'd1, 4'd3, 4'b0000, "sub_4_1");
        step(4'd4, 4'd1, 4'd2, 4'd4, 4'b0000, "mul_4_1");
        step(4'd4, 4'd1, 4'd4, 4'd4, 4'b0000, "div_4_1");
        step(4'd4, 4'd1, 4'd3, 4'd0, 4'b0100, "mod_4_1");
        step(4'd4, 4'd1, 4'd7, 4'd5, 4'b0000, "xor_4_1");
        step(4'd4, 4'd1, 4'd8, 4'd8, 4'b1000, "rol_4_1");
        step(4'd4, 4'd1, 4'd9, 4'd2, 4'b0000, "ror_4_1");

        // Edge arithmetic, zero divisors, rotate corners, illegal op
        step(4'd15, 4'd1,  4'd0,  4'd0,  4'b0110, "add_carry");
        step(4'd2,  4'd3,  4'd1,  4'd15, 4'b1010, "sub_borrow");
        step(4'd7,  4'd1,  4'd0,  4'd8,  4'b1001, "add_ovf");
        step(4'd8,  4'd1,  4'd1,  4'd7,  4'b0001, "sub_ovf");
        step(4'd4,  4'd4,  4'd2,  4'd0,  4'b0111, "mul_ovf");
        step(4'd9,  4'd0,  4'd4,  4'd15, 4'b1001, "div_zero");
        step(4'd9,  4'd0,  4'd3,  4'd9,  4'b1001, "mod_zero");
        step(4'd5,  4'd4,  4'd8,  4'd5,  4'b0000, "rol_amt0");
        step(4'd9,  4'd1,  4'd8,  4'd3,  4'b0010, "rol_carry");
        step(4'd1,  4'd6,  4'd9,  4'd4,  4'b0000, "ror_mod");
        step(4'd12, 4'd10, 4'd5,  4'd8,  4'b1000, "and_neg");
        step(4'd12, 4'd10, 4'd6,  4'd14, 4'b1000, "or_neg");
        step(4'd3,  4'd5,  4'd12, 4'd0,  4'b0101, "illegal");

        // Flush, then assert reset between edges while the output is nonzero
        step(4'd6, 4'd3, 4'd0, 4'd9, 4'b1001, "pre_reset");
        @(negedge clk);
        pop_check();
        rst_n = 1'b0;
        #1;
        check("async_reset.res",   8'(salida), 8'h00);
        check("async_reset.flags", 8'(flags),  8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back random ops against the model
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            rs = 4'($urandom_range(0, 15));
            m  = model(int'(ra), int'(rb), int'(rs));
            step(ra, rb, rs, m[W+3:4], m[3:0], $sformatf("rand%0d_op%0d", i, rs));
        end
        @(negedge clk);
        pop_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_calcu_alu
`default_nettype wire
